input_ctrl: RTL and testbench

Write-side port controller for the shared multi-port packet cache, one instance per input port.
- Accepts a framed 32-bit word stream and allocates 64-byte cache blocks (16 words) from the free-block manager.
- Writes header and payload words into cache SRAM, and enqueues each filled block to the destination output queue.
- The header word is written as word 0 of the first block. The output-side controller later recovers the length from it.

---
 rtl/mpc_pkg.sv | 36 +++
 rtl/input_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_input_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpc_pkg : shared constants, FSM states and length helpers for the    |
// |           multi-port packet cache port controllers.  Rev 1.0         |
// +----------------------------------------------------------------------+
package mpc_pkg;

   localparam int WORD_BYTES    = 4;
   localparam int WORDS_PER_BLK = 16;
   localparam int BLK_BYTES     = WORD_BYTES * WORDS_PER_BLK;

   // Header word layout: len in the low bits, dest directly above it.
   localparam int HDR_LEN_LSB   = 0;

   // Working width of the helper functions; callers size-cast in and out.
   localparam int LEN_FN_W      = 16;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_BLK = 2'd1,
      S_WRITE    = 2'd2,
      S_DROP     = 2'd3
   } ic_state_e;

   // Beats in a packet including the header word: ceil((len + 4) / 4).
   function automatic logic [LEN_FN_W-1:0] beats_of(input logic [LEN_FN_W-1:0] len);
      beats_of = (len + LEN_FN_W'(2 * WORD_BYTES - 1)) / LEN_FN_W'(WORD_BYTES);
   endfunction

   // Cache blocks occupied by a packet including the header word.
   function automatic logic [LEN_FN_W-1:0] blocks_of(input logic [LEN_FN_W-1:0] len);
      blocks_of = (len + LEN_FN_W'(WORD_BYTES + BLK_BYTES - 1)) / LEN_FN_W'(BLK_BYTES);
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_ctrl : write-side port controller; packs a framed word stream  |
// |              into cache blocks and enqueues each filled block.  Rev 1.0 |
// +----------------------------------------------------------------------+
module input_ctrl #(
   parameter int PORTNUM        = 16,
   parameter int BLK_ADDR_WIDTH = 10,
   parameter int LEN_WIDTH      = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_BLK  = 16
) (
   input  logic                                            i_clk,
   input  logic                                            i_rst_n,
   input  logic [DATA_WIDTH-1:0]                           i_data,
   input  logic                                            i_data_vld,
   input  logic                                            i_sop,
   input  logic                                            i_eop,
   output logic                                            o_data_rdy,
   output logic                                            o_blk_req,
   input  logic [BLK_ADDR_WIDTH-1:0]                       i_blk_addr,
   input  logic                                            i_blk_addr_vld,
   output logic                                            o_wr_en,
   output logic [BLK_ADDR_WIDTH+$clog2(WORDS_PER_BLK)-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0]                           o_wr_data,
   output logic                                            o_enq_vld,
   output logic [$clog2(PORTNUM)-1:0]                      o_enq_port,
   output logic [BLK_ADDR_WIDTH-1:0]                       o_enq_addr,
   output logic                                            o_enq_last,
   output logic                                            o_len_err
);
   import mpc_pkg::*;

   localparam int c_DEST_W   = $clog2(PORTNUM);
   localparam int c_OFF_W    = $clog2(WORDS_PER_BLK);
   localparam int c_CNT_W    = LEN_WIDTH + 1;
   localparam int c_DEST_LSB = HDR_LEN_LSB + LEN_WIDTH;
   localparam int c_WADDR_W  = BLK_ADDR_WIDTH + c_OFF_W;

   ic_state_e                 r_state,     w_state_nxt;
   logic [BLK_ADDR_WIDTH-1:0] r_blk,       w_blk_nxt;
   logic [c_OFF_W-1:0]        r_wcnt,      w_wcnt_nxt;
   logic [c_CNT_W-1:0]        r_bcnt,      w_bcnt_nxt;
   logic [c_CNT_W-1:0]        r_exp,       w_exp_nxt;
   logic [c_DEST_W-1:0]       r_dest,      w_dest_nxt;

   logic                      r_wr_en,     w_wr_en_nxt;
   logic [c_WADDR_W-1:0]      r_wr_addr,   w_wr_addr_nxt;
   logic [DATA_WIDTH-1:0]     r_wr_data,   w_wr_data_nxt;
   logic                      r_enq_vld,   w_enq_vld_nxt;
   logic [c_DEST_W-1:0]       r_enq_port,  w_enq_port_nxt;
   logic [BLK_ADDR_WIDTH-1:0] r_enq_addr,  w_enq_addr_nxt;
   logic                      r_enq_last,  w_enq_last_nxt;
   logic                      r_len_err,   w_len_err_nxt;

   logic [c_CNT_W-1:0]        w_bcnt_inc;
   logic                      w_last_beat;
   logic                      w_blk_end;

   assign o_data_rdy  = (r_state == S_WRITE) || (r_state == S_DROP);
   assign o_blk_req   = (r_state == S_WAIT_BLK);

   assign w_bcnt_inc  = r_bcnt + c_CNT_W'(1);
   assign w_last_beat = (w_bcnt_inc == r_exp);
   assign w_blk_end   = (r_wcnt == c_OFF_W'(WORDS_PER_BLK - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_blk      <= '0;
         r_wcnt     <= '0;
         r_bcnt     <= '0;
         r_exp      <= '0;
         r_dest     <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_enq_vld  <= 1'b0;
         r_enq_port <= '0;
         r_enq_addr <= '0;
         r_enq_last <= 1'b0;
         r_len_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_blk      <= w_blk_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_bcnt     <= w_bcnt_nxt;
         r_exp      <= w_exp_nxt;
         r_dest     <= w_dest_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_enq_vld  <= w_enq_vld_nxt;
         r_enq_port <= w_enq_port_nxt;
         r_enq_addr <= w_enq_addr_nxt;
         r_enq_last <= w_enq_last_nxt;
         r_len_err  <= w_len_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_blk_nxt      = r_blk;
      w_wcnt_nxt     = r_wcnt;
      w_bcnt_nxt     = r_bcnt;
      w_exp_nxt      = r_exp;
      w_dest_nxt     = r_dest;
      w_wr_en_nxt    = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      w_enq_vld_nxt  = 1'b0;
      w_enq_port_nxt = r_enq_port;
      w_enq_addr_nxt = r_enq_addr;
      w_enq_last_nxt = r_enq_last;
      w_len_err_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            // The header stays on the bus here; it is consumed as word 0 in S_WRITE.
            if (i_data_vld) begin
               if (i_sop) begin
                  w_dest_nxt  = i_data[c_DEST_LSB +: c_DEST_W];
                  w_exp_nxt   = c_CNT_W'(beats_of(LEN_FN_W'(i_data[HDR_LEN_LSB +: LEN_WIDTH])));
                  w_bcnt_nxt  = '0;
                  w_state_nxt = S_WAIT_BLK;
               end else begin
                  w_state_nxt = S_DROP;
               end
            end
         end

         S_WAIT_BLK: begin
            if (i_blk_addr_vld) begin
               w_blk_nxt   = i_blk_addr;
               w_wcnt_nxt  = '0;
               w_state_nxt = S_WRITE;
            end
         end

         S_WRITE: begin
            if (i_data_vld) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = {r_blk, r_wcnt};
               w_wr_data_nxt = i_data;
               w_bcnt_nxt    = w_bcnt_inc;
               w_wcnt_nxt    = r_wcnt + c_OFF_W'(1);
               if (i_eop || w_last_beat) begin
                  // Closing takes priority over a full block, so a packet ending
                  // on word 15 never requests a spare block.
                  w_enq_vld_nxt  = 1'b1;
                  w_enq_port_nxt = r_dest;
                  w_enq_addr_nxt = r_blk;
                  w_enq_last_nxt = 1'b1;
                  w_len_err_nxt  = i_eop ^ w_last_beat;
                  w_state_nxt    = i_eop ? S_IDLE : S_DROP;
               end else if (w_blk_end) begin
                  w_enq_vld_nxt  = 1'b1;
                  w_enq_port_nxt = r_dest;
                  w_enq_addr_nxt = r_blk;
                  w_enq_last_nxt = 1'b0;
                  w_state_nxt    = S_WAIT_BLK;
               end
            end
         end

         S_DROP: begin
            if (i_data_vld && i_eop) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_enq_vld  = r_enq_vld;
   assign o_enq_port = r_enq_port;
   assign o_enq_addr = r_enq_addr;
   assign o_enq_last = r_enq_last;
   assign o_len_err  = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_ctrl : randomized packet stream against a packet-level       |
// |                 model of block fill, enqueue and length errors. Rev 1.0 |
// +----------------------------------------------------------------------+
module tb_input_ctrl;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [3:0] port;
      logic [9:0] addr;
      logic       last;
      logic       err;
   } enq_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_data;
   logic        i_data_vld;
   logic        i_sop;
   logic        i_eop;
   logic        o_data_rdy;
   logic        o_blk_req;
   logic [9:0]  i_blk_addr;
   logic        i_blk_addr_vld;
   logic        o_wr_en;
   logic [13:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic        o_enq_vld;
   logic [3:0]  o_enq_port;
   logic [9:0]  o_enq_addr;
   logic        o_enq_last;
   logic        o_len_err;

   input_ctrl #(
      .PORTNUM        (16),
      .BLK_ADDR_WIDTH (10),
      .LEN_WIDTH      (10),
      .DATA_WIDTH     (32),
      .WORDS_PER_BLK  (16)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_data         (i_data),
      .i_data_vld     (i_data_vld),
      .i_sop          (i_sop),
      .i_eop          (i_eop),
      .o_data_rdy     (o_data_rdy),
      .o_blk_req      (o_blk_req),
      .i_blk_addr     (i_blk_addr),
      .i_blk_addr_vld (i_blk_addr_vld),
      .o_wr_en        (o_wr_en),
      .o_wr_addr      (o_wr_addr),
      .o_wr_data      (o_wr_data),
      .o_enq_vld      (o_enq_vld),
      .o_enq_port     (o_enq_port),
      .o_enq_addr     (o_enq_addr),
      .o_enq_last     (o_enq_last),
      .o_len_err      (o_len_err)
   );

   always #5 i_clk = ~i_clk;

   wr_t  exp_wr[$];
   enq_t exp_enq[$];
   wr_t  ew;
   enq_t ee;
   enq_t last_enq_seen;

   int checks = 0;
   int errors = 0;
   int n_wr = 0, n_enq = 0, n_err = 0, n_req_cyc = 0, n_req_rise = 0;
   logic prev_req = 1'b0;
   int gidx = 0;
   int model_gidx = 0;
   int grant_delay = 1;
   int req_cycles = 0;

   function automatic logic [9:0] addr_of(input int g);
      return 10'((g * 37 + 5) % 1024);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Free-block manager: grants one block after grant_delay cycles of request.
   initial begin
      i_blk_addr     = '0;
      i_blk_addr_vld = 1'b0;
      forever begin
         @(negedge i_clk);
         i_blk_addr_vld = 1'b0;
         if (i_rst_n && o_blk_req) begin
            if (req_cycles + 1 >= grant_delay) begin
               i_blk_addr     = addr_of(gidx);
               i_blk_addr_vld = 1'b1;
               gidx++;
               req_cycles = 0;
            end else begin
               req_cycles++;
            end
         end
      end
   end

   // Per-cycle compare of DUT activity against the model's expectation queues.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_blk_req) n_req_cyc++;
         if (o_blk_req && !prev_req) n_req_rise++;
         prev_req = o_blk_req;
         checks++;
         if (o_blk_req && o_data_rdy) begin
            errors++;
            $display("FAIL req_rdy_overlap: got req=1 rdy=1, required not both");
         end
         if (o_wr_en) begin
            n_wr++;
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", o_wr_addr, o_wr_data);
            end else begin
               ew = exp_wr.pop_front();
               if (o_wr_addr !== ew.addr || o_wr_data !== ew.data) begin
                  errors++;
                  $display("FAIL wr_beat: got addr=%h data=%h, required addr=%h data=%h",
                           o_wr_addr, o_wr_data, ew.addr, ew.data);
               end
            end
         end
         if (o_len_err) n_err++;
         if (o_enq_vld) begin
            n_enq++;
            last_enq_seen = {o_enq_port, o_enq_addr, o_enq_last, o_len_err};
            checks++;
            if (exp_enq.size() == 0) begin
               errors++;
               $display("FAIL enq_unexpected: got port=%0d addr=%h last=%0b, required no enqueue",
                        o_enq_port, o_enq_addr, o_enq_last);
            end else begin
               ee = exp_enq.pop_front();
               if ({o_enq_port, o_enq_addr, o_enq_last, o_len_err} !== ee) begin
                  errors++;
                  $display("FAIL enq: got port=%0d addr=%h last=%0b err=%0b, required port=%0d addr=%h last=%0b err=%0b",
                           o_enq_port, o_enq_addr, o_enq_last, o_len_err, ee.port, ee.addr, ee.last, ee.err);
               end
            end
         end else begin
            checks++;
            if (o_len_err) begin
               errors++;
               $display("FAIL len_err_alone: got len_err=1 without enqueue, required 0");
            end
         end
      end else begin
         prev_req = 1'b0;
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
      int guard;
      i_data     = d;
      i_sop      = sop;
      i_eop      = eop;
      i_data_vld = 1'b1;
      guard      = 0;
      while (!o_data_rdy && guard < 4000) begin
         @(negedge i_clk);
         guard++;
      end
      checks++;
      if (!o_data_rdy) begin
         errors++;
         $display("FAIL beat_timeout: got ready=0 for %0d cycles, required 1", guard);
      end
      @(negedge i_clk);
      i_data_vld = 1'b0;
      i_sop      = 1'b0;
      i_eop      = 1'b0;
   endtask

   // Model: beat k of a packet lands at word k%16 of its (k/16)-th block, writing
   // min(beats, expected) words; every used block is enqueued, the final one as last.
   task automatic send_packet(input int len, input int dest, input int nbeats,
                              input bit with_sop, input int cut, input bit gaps);
      logic [31:0] beats[$];
      logic [31:0] d;
      int          exp_b, n, nblk;
      wr_t         w;
      enq_t        e;
      for (int k = 0; k < nbeats; k++) begin
         d = $urandom;
         if (k == 0 && with_sop) begin
            d[13:10] = 4'(dest);
            d[9:0]   = 10'(len);
         end
         beats.push_back(d);
      end
      if (with_sop) begin
         exp_b = (len + 4 + 3) / 4;
         n     = (nbeats < exp_b) ? nbeats : exp_b;
         nblk  = (n + 15) / 16;
         for (int k = 0; k < n; k++) begin
            w.addr = {addr_of(model_gidx + k / 16), 4'(k % 16)};
            w.data = beats[k];
            exp_wr.push_back(w);
         end
         for (int j = 0; j < nblk; j++) begin
            e.port = 4'(dest);
            e.addr = addr_of(model_gidx + j);
            e.last = (j == nblk - 1);
            e.err  = (j == nblk - 1) && (nbeats != exp_b);
            enq_t_push(e);
         end
         model_gidx += nblk;
      end
      for (int k = 0; k < nbeats && k < cut; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) @(negedge i_clk);
         send_beat(beats[k], with_sop && (k == 0), k == nbeats - 1);
      end
   endtask

   task automatic enq_t_push(input enq_t e);
      exp_enq.push_back(e);
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   int w0, e0, r0, q0, f0;
   int len, nb, eb, mode;

   initial begin
      i_rst_n    = 1'b0;
      i_data     = '0;
      i_data_vld = 1'b0;
      i_sop      = 1'b0;
      i_eop      = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_rdy",   o_data_rdy, 0);
      check("rst_req",   o_blk_req, 0);
      check("rst_wr",    {o_wr_en, o_wr_addr, o_wr_data}, 0);
      check("rst_enq",   {o_enq_vld, o_enq_port, o_enq_addr, o_enq_last}, 0);
      check("rst_err",   o_len_err, 0);
      i_rst_n = 1'b1;
      drain(2);

      // len 60: exactly one full block
      w0 = n_wr; e0 = n_enq; r0 = n_err;
      send_packet(60, 5, 16, 1'b1, 1000, 1'b0);
      drain(4);
      check("c1_writes", n_wr - w0, 16);
      check("c1_enqs",   n_enq - e0, 1);
      check("c1_errs",   n_err - r0, 0);
      check("c1_port",   last_enq_seen.port, 5);
      check("c1_last",   last_enq_seen.last, 1);

      // len 61: spills one word into a second block
      w0 = n_wr; e0 = n_enq; f0 = n_req_rise;
      send_packet(61, 3, 17, 1'b1, 1000, 1'b0);
      drain(4);
      check("c2_writes", n_wr - w0, 17);
      check("c2_enqs",   n_enq - e0, 2);
      check("c2_reqs",   n_req_rise - f0, 2);
      check("c2_port",   last_enq_seen.port, 3);

      // Empty free list for 20 cycles
      grant_delay = 20;
      w0 = n_wr; q0 = n_req_cyc;
      send_packet(20, 9, 6, 1'b1, 1000, 1'b0);
      drain(4);
      check("c3_req_cycles", n_req_cyc - q0, 20);
      check("c3_writes",     n_wr - w0, 6);
      grant_delay = 1;

      // Short packet: eop before expected count
      w0 = n_wr; e0 = n_enq; r0 = n_err;
      send_packet(8, 1, 2, 1'b1, 1000, 1'b0);
      drain(4);
      check("c4_writes", n_wr - w0, 2);
      check("c4_enqs",   n_enq - e0, 1);
      check("c4_errs",   n_err - r0, 1);

      // Long packet: overrun beats are flushed
      w0 = n_wr; e0 = n_enq; r0 = n_err;
      send_packet(8, 2, 5, 1'b1, 1000, 1'b0);
      drain(4);
      check("c5_writes", n_wr - w0, 3);
      check("c5_enqs",   n_enq - e0, 1);
      check("c5_errs",   n_err - r0, 1);
      check("c5_idle",   {o_data_rdy, o_blk_req}, 0);

      // Ends exactly on word 15 of the second block: no third request
      w0 = n_wr; e0 = n_enq; f0 = n_req_rise;
      send_packet(124, 7, 32, 1'b1, 1000, 1'b0);
      drain(4);
      check("c6_writes", n_wr - w0, 32);
      check("c6_enqs",   n_enq - e0, 2);
      check("c6_reqs",   n_req_rise - f0, 2);

      // Headerless beats dropped, then a reset in the middle of a packet
      w0 = n_wr; e0 = n_enq;
      send_packet(0, 0, 3, 1'b0, 1000, 1'b0);
      drain(3);
      check("c7_drop_writes", n_wr - w0, 0);
      check("c7_drop_enqs",   n_enq - e0, 0);
      send_packet(40, 4, 11, 1'b1, 5, 1'b0);
      #2 i_rst_n = 1'b0;
      #1;
      check("c7_rst_rdy_req", {o_data_rdy, o_blk_req}, 0);
      check("c7_rst_outs", {o_wr_en, o_wr_addr, o_wr_data, o_enq_vld, o_enq_port,
                            o_enq_addr, o_enq_last, o_len_err}, 0);
      exp_wr.delete();
      exp_enq.delete();
      drain(3);
      model_gidx = gidx;
      i_rst_n = 1'b1;
      drain(2);
      w0 = n_wr; e0 = n_enq; r0 = n_err;
      send_packet(30, 12, 9, 1'b1, 1000, 1'b0);
      drain(4);
      check("c7_next_writes", n_wr - w0, 9);
      check("c7_next_enqs",   n_enq - e0, 1);
      check("c7_next_errs",   n_err - r0, 0);

      // Randomized traffic
      for (int p = 0; p < 40; p++) begin
         grant_delay = $urandom_range(1, 4);
         len  = $urandom_range(0, 400);
         eb   = (len + 7) / 4;
         mode = $urandom_range(0, 9);
         if (mode == 0 && eb > 1)  nb = $urandom_range(1, eb - 1);
         else if (mode == 1)       nb = eb + $urandom_range(1, 3);
         else                      nb = eb;
         send_packet(len, $urandom_range(0, 15), nb, ($urandom_range(0, 9) != 0), 1000, 1'b1);
         if ($urandom_range(0, 2) == 0) drain($urandom_range(1, 3));
      end
      drain(10);
      check("end_wr_queue",  exp_wr.size(), 0);
      check("end_enq_queue", exp_enq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
